// File: rtl/pc_ras.sv
// Fetch PC register with trap redirect and a circular return-address stack.
// The PC and the stack pointer/count update on the rising edge; ras_top is read combinationally.
module pc_ras #(
  parameter int unsigned     XLEN      = 32,
  parameter int unsigned     INC       = 1,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter int unsigned     RAS_DEPTH = 4,
  parameter int unsigned     RAS_PTR_W = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 load,
  input  logic [2:0]           pc_sel,
  input  logic [XLEN-1:0]      jal,
  input  logic [XLEN-1:0]      jalr,
  input  logic [XLEN-1:0]      branch,
  input  logic                 trap,
  input  logic [XLEN-1:0]      trap_vec,
  input  logic                 ras_push,
  input  logic                 ras_pop,
  input  logic                 ras_flush,
  output logic [XLEN-1:0]      pc,
  output logic [XLEN-1:0]      ras_top,
  output logic                 ras_empty,
  output logic [RAS_PTR_W:0]   ras_count
);

  typedef enum logic [2:0] {
    SEL_PLUS     = 3'd0,
    SEL_JAL      = 3'd1,
    SEL_JALR     = 3'd2,
    SEL_BRANCH   = 3'd3,
    SEL_RAS_RET  = 3'd4,
    SEL_TRAP_VEC = 3'd5
  } pc_sel_e;

  logic [XLEN-1:0]      stack [RAS_DEPTH];
  logic [RAS_PTR_W-1:0] top_ptr;
  logic [RAS_PTR_W-1:0] ptr_next;
  logic [RAS_PTR_W:0]   count_next;
  logic [RAS_PTR_W-1:0] wr_ptr;
  logic                 wr_en;
  logic [XLEN-1:0]      pc_inc;
  logic [XLEN-1:0]      pc_next;
  logic                 ras_full;
  logic                 do_push;
  logic                 do_pop;

  assign pc_inc    = pc + XLEN'(INC);
  assign ras_empty = (ras_count == '0);
  assign ras_full  = (ras_count == (RAS_PTR_W+1)'(RAS_DEPTH));
  assign ras_top   = ras_empty ? '0 : stack[top_ptr];
  assign do_push   = load && !trap && ras_push;
  assign do_pop    = load && !trap && ras_pop;

  always_comb begin
    pc_next = pc;
    case (pc_sel_e'(pc_sel))
      SEL_PLUS:     pc_next = pc_inc;
      SEL_JAL:      pc_next = jal;
      SEL_JALR:     pc_next = jalr;
      SEL_BRANCH:   pc_next = branch;
      SEL_RAS_RET:  pc_next = ras_empty ? jalr : ras_top;
      SEL_TRAP_VEC: pc_next = trap_vec;
      default:      pc_next = pc;
    endcase
  end

  // Push+pop on a non-empty stack rewrites the top in place; a full push
  // advances onto the oldest slot so the newest return always survives.
  always_comb begin
    ptr_next   = top_ptr;
    count_next = ras_count;
    wr_ptr     = top_ptr;
    wr_en      = 1'b0;
    if (ras_flush) begin
      ptr_next   = '0;
      count_next = '0;
    end else if (do_push && do_pop && !ras_empty) begin
      wr_en = 1'b1;
    end else if (do_push) begin
      ptr_next = top_ptr + RAS_PTR_W'(1);
      wr_ptr   = top_ptr + RAS_PTR_W'(1);
      wr_en    = 1'b1;
      if (!ras_full) count_next = ras_count + (RAS_PTR_W+1)'(1);
    end else if (do_pop && !ras_empty) begin
      ptr_next   = top_ptr - RAS_PTR_W'(1);
      count_next = ras_count - (RAS_PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc <= RESET_VEC;
    end else if (trap) begin
      pc <= trap_vec;
    end else if (load) begin
      pc <= pc_next;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      top_ptr   <= '0;
      ras_count <= '0;
    end else begin
      top_ptr   <= ptr_next;
      ras_count <= count_next;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && wr_en) begin
      stack[wr_ptr] <= pc_inc;
    end
  end

endmodule

// File: tb/tb_pc_ras.sv
// Directed, table-driven bench for pc_ras (RESET_VEC=0x100, INC=1, depth 4).
module tb_pc_ras;

  logic        clock;
  logic        reset;
  logic        load;
  logic [2:0]  pc_sel;
  logic [31:0] jal;
  logic [31:0] jalr;
  logic [31:0] branch;
  logic        trap;
  logic [31:0] trap_vec;
  logic        ras_push;
  logic        ras_pop;
  logic        ras_flush;
  logic [31:0] pc;
  logic [31:0] ras_top;
  logic        ras_empty;
  logic [2:0]  ras_count;

  int tests_run = 0;
  int tests_failed = 0;

  pc_ras #(
    .XLEN(32), .INC(1), .RESET_VEC(32'h100), .RAS_DEPTH(4), .RAS_PTR_W(2)
  ) dut (
    .clock(clock), .reset(reset), .load(load), .pc_sel(pc_sel),
    .jal(jal), .jalr(jalr), .branch(branch), .trap(trap), .trap_vec(trap_vec),
    .ras_push(ras_push), .ras_pop(ras_pop), .ras_flush(ras_flush),
    .pc(pc), .ras_top(ras_top), .ras_empty(ras_empty), .ras_count(ras_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        rst;
    logic        ld;
    logic [2:0]  sel;
    logic [31:0] tgt;
    logic        tr;
    logic [31:0] tv;
    logic        psh;
    logic        pp;
    logic        fl;
    logic [31:0] exp_pc;
    logic [31:0] exp_top;
    logic [2:0]  exp_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic ld, logic [2:0] sel, logic [31:0] tgt,
                              logic tr, logic [31:0] tv, logic psh, logic pp, logic fl,
                              logic [31:0] epc, logic [31:0] etop, logic [2:0] ecnt);
    vec_t v;
    v.rst = rst; v.ld = ld; v.sel = sel; v.tgt = tgt; v.tr = tr; v.tv = tv;
    v.psh = psh; v.pp = pp; v.fl = fl;
    v.exp_pc = epc; v.exp_top = etop; v.exp_cnt = ecnt;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One target value drives jal/jalr/branch; pc_sel decides which one matters.
  task automatic applyStimulus(vec_t v);
    @(negedge clock);
    reset = v.rst; load = v.ld; pc_sel = v.sel;
    jal = v.tgt; jalr = v.tgt; branch = v.tgt;
    trap = v.tr; trap_vec = v.tv;
    ras_push = v.psh; ras_pop = v.pp; ras_flush = v.fl;
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(string tag, vec_t v);
    check({tag, " pc"},        pc,                v.exp_pc);
    check({tag, " ras_top"},   ras_top,           v.exp_top);
    check({tag, " ras_count"}, {29'd0, ras_count}, {29'd0, v.exp_cnt});
    check({tag, " ras_empty"}, {31'd0, ras_empty}, {31'd0, (v.exp_cnt == 3'd0)});
  endtask

  initial begin
    vec_t v;
    reset = 1'b0; load = 1'b0; pc_sel = 3'd0; jal = '0; jalr = '0; branch = '0;
    trap = 1'b0; trap_vec = '0; ras_push = 1'b0; ras_pop = 1'b0; ras_flush = 1'b0;

    //             rst ld sel  tgt            tr tv        psh pp fl  pc             top        cnt
    vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,   0, 0, 0, 32'h100,      32'h0,   3'd0));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,   0, 0, 0, 32'h101,      32'h0,   3'd0));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,   0, 0, 0, 32'h102,      32'h0,   3'd0));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,   0, 0, 0, 32'h103,      32'h0,   3'd0));
    vecs.push_back(mk(0, 1, 1, 32'h40,       0, 32'h0,   0, 0, 0, 32'h40,       32'h0,   3'd0));
    vecs.push_back(mk(0, 1, 3, 32'h80,       0, 32'h0,   0, 0, 0, 32'h80,       32'h0,   3'd0));
    vecs.push_back(mk(0, 1, 6, 32'h55,       0, 32'h0,   0, 0, 0, 32'h80,       32'h0,   3'd0));
    vecs.push_back(mk(0, 0, 1, 32'h40,       0, 32'h0,   0, 0, 0, 32'h80,       32'h0,   3'd0));
    vecs.push_back(mk(0, 0, 1, 32'h40,       1, 32'h200, 1, 0, 0, 32'h200,      32'h0,   3'd0));
    vecs.push_back(mk(0, 1, 1, 32'h10,       0, 32'h0,   0, 0, 0, 32'h10,       32'h0,   3'd0));
    vecs.push_back(mk(0, 1, 1, 32'h20,       0, 32'h0,   1, 0, 0, 32'h20,       32'h11,  3'd1));
    vecs.push_back(mk(0, 1, 1, 32'h30,       0, 32'h0,   1, 0, 0, 32'h30,       32'h21,  3'd2));
    vecs.push_back(mk(0, 1, 1, 32'h40,       0, 32'h0,   1, 0, 0, 32'h40,       32'h31,  3'd3));
    vecs.push_back(mk(0, 1, 1, 32'h50,       0, 32'h0,   1, 0, 0, 32'h50,       32'h41,  3'd4));
    vecs.push_back(mk(0, 1, 1, 32'h60,       0, 32'h0,   1, 0, 0, 32'h60,       32'h51,  3'd4));
    vecs.push_back(mk(0, 1, 4, 32'h0,        0, 32'h0,   0, 1, 0, 32'h51,       32'h41,  3'd3));
    vecs.push_back(mk(0, 1, 4, 32'h0,        0, 32'h0,   0, 1, 0, 32'h41,       32'h31,  3'd2));
    vecs.push_back(mk(0, 1, 4, 32'h0,        0, 32'h0,   0, 1, 0, 32'h31,       32'h21,  3'd1));
    vecs.push_back(mk(0, 1, 4, 32'h0,        0, 32'h0,   0, 1, 0, 32'h21,       32'h0,   3'd0));
    vecs.push_back(mk(0, 1, 4, 32'h99,       0, 32'h0,   0, 1, 0, 32'h99,       32'h0,   3'd0));
    vecs.push_back(mk(0, 1, 1, 32'h60,       0, 32'h0,   1, 0, 0, 32'h60,       32'h9A,  3'd1));
    vecs.push_back(mk(0, 1, 1, 32'h70,       0, 32'h0,   1, 0, 0, 32'h70,       32'h61,  3'd2));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,   1, 1, 0, 32'h71,       32'h71,  3'd2));
    vecs.push_back(mk(0, 1, 6, 32'h0,        0, 32'h0,   0, 1, 0, 32'h71,       32'h9A,  3'd1));
    vecs.push_back(mk(0, 1, 1, 32'h80,       0, 32'h0,   1, 0, 0, 32'h80,       32'h72,  3'd2));
    vecs.push_back(mk(0, 1, 1, 32'h90,       0, 32'h0,   1, 0, 0, 32'h90,       32'h81,  3'd3));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,   1, 0, 1, 32'h91,       32'h0,   3'd0));
    vecs.push_back(mk(0, 1, 1, 32'hFFFFFFFF, 0, 32'h0,   0, 0, 0, 32'hFFFFFFFF, 32'h0,   3'd0));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,   0, 0, 0, 32'h0,        32'h0,   3'd0));
    vecs.push_back(mk(0, 1, 1, 32'h30,       0, 32'h0,   1, 0, 0, 32'h30,       32'h1,   3'd1));
    vecs.push_back(mk(1, 1, 1, 32'h55,       0, 32'h0,   1, 0, 0, 32'h100,      32'h0,   3'd0));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,   0, 0, 0, 32'h101,      32'h0,   3'd0));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,   1, 0, 0, 32'h102,      32'h102, 3'd1));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,   1, 1, 0, 32'h102,      32'h102, 3'd1));
    vecs.push_back(mk(0, 1, 4, 32'h0,        0, 32'h0,   0, 1, 0, 32'h102,      32'h0,   3'd0));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d", i), vecs[i]);
    end

    // Trap with load=1 ignores pop and pc_sel, then a trap cycle still honours flush.
    v = mk(0, 1, 1, 32'h10, 0, 32'h0, 1, 0, 0, 32'h10, 32'h103, 3'd1);
    applyStimulus(v);
    checkOutput("trap_setup", v);
    v = mk(0, 1, 1, 32'h77, 1, 32'h300, 0, 1, 0, 32'h300, 32'h103, 3'd1);
    applyStimulus(v);
    checkOutput("trap_pop", v);
    v = mk(0, 0, 0, 32'h0, 1, 32'h400, 0, 0, 1, 32'h400, 32'h0, 3'd0);
    applyStimulus(v);
    checkOutput("trap_flush", v);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
